// File: rtl/ptrgen.sv
// AU-4 pointer generator: builds the 9-byte H1 Y Y H2 1* 1* H3 H3 H3 pointer field per frame,
// executing offset loads (NDF), +/- justifications with I/D inversion, and AU-AIS insertion.
module ptrgen #(
  parameter logic [9:0] MAXOFFSET   = 10'd782,
  parameter logic [1:0] HOLDOFF     = 2'd3,
  parameter logic [1:0] SSBITS      = 2'b10,
  parameter logic [9:0] INIT_OFFSET = 10'd0
) (
  input  logic       clk19,
  input  logic       rst,
  input  logic       txsof,
  input  logic       en,
  input  logic [9:0] ld_offset,
  input  logic       ld_req,
  input  logic       inc_req,
  input  logic       dec_req,
  input  logic       ais_req,
  output logic [7:0] dout,
  output logic       vld,
  output logic       pjust,
  output logic       njust,
  output logic       ack,
  output logic       err,
  output logic [9:0] act_offset,
  output logic       ais
);

  localparam int unsigned IW     = 4;
  localparam int unsigned NBYTES = 9;
  localparam logic [3:0]  NDF_NEW  = 4'b1001;
  localparam logic [3:0]  NDF_NORM = 4'b0110;
  localparam logic [9:0]  I_MASK   = 10'h2AA;
  localparam logic [9:0]  D_MASK   = 10'h155;

  typedef enum logic {ST_NORM = 1'b0, ST_AIS = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;

  logic          ld_pend;
  logic          inc_pend;
  logic          dec_pend;
  logic [9:0]    ld_val;
  logic [1:0]    holdoff;
  logic [IW-1:0] idx;
  logic [3:0]    fr_ndf;
  logic [9:0]    fr_ptr;

  logic          exec_ld_c;
  logic          clr_adj_c;
  logic          ack_c;
  logic          pj_c;
  logic          nj_c;
  logic [3:0]    ndf_c;
  logic [9:0]    ptr_c;
  logic [9:0]    act_nxt_c;
  logic [1:0]    hold_nxt_c;
  logic          ld_ok_c;
  logic          ld_bad_c;
  logic [7:0]    byte_c;

  // State register: NORM / AIS, only changes at frame start
  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) state <= ST_NORM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (txsof) state_nxt = ais_req ? ST_AIS : ST_NORM;
  end

  // Frame decision, consumed only on txsof; priority AIS > LD > leave-AIS > INC > DEC > NORMAL
  always_comb begin
    exec_ld_c  = 1'b0;
    clr_adj_c  = 1'b0;
    ack_c      = 1'b0;
    pj_c       = 1'b0;
    nj_c       = 1'b0;
    ndf_c      = NDF_NORM;
    ptr_c      = act_offset;
    act_nxt_c  = act_offset;
    hold_nxt_c = (holdoff == 2'd0) ? 2'd0 : holdoff - 2'd1;
    if (ais_req) begin
      hold_nxt_c = holdoff;
    end else if (ld_pend) begin
      exec_ld_c  = 1'b1;
      clr_adj_c  = 1'b1;
      ack_c      = 1'b1;
      ndf_c      = NDF_NEW;
      ptr_c      = ld_val;
      act_nxt_c  = ld_val;
      hold_nxt_c = HOLDOFF;
    end else if (state == ST_AIS) begin
      ndf_c      = NDF_NEW;
      hold_nxt_c = HOLDOFF;
    end else if (inc_pend && holdoff == 2'd0) begin
      clr_adj_c  = 1'b1;
      ack_c      = 1'b1;
      pj_c       = 1'b1;
      ptr_c      = act_offset ^ I_MASK;
      act_nxt_c  = (act_offset == MAXOFFSET) ? 10'd0 : act_offset + 10'd1;
      hold_nxt_c = HOLDOFF;
    end else if (dec_pend && holdoff == 2'd0) begin
      clr_adj_c  = 1'b1;
      ack_c      = 1'b1;
      nj_c       = 1'b1;
      ptr_c      = act_offset ^ D_MASK;
      act_nxt_c  = (act_offset == 10'd0) ? MAXOFFSET : act_offset - 10'd1;
      hold_nxt_c = HOLDOFF;
    end
  end

  assign ld_ok_c  = ld_req && (ld_offset <= MAXOFFSET);
  assign ld_bad_c = ld_req && (ld_offset > MAXOFFSET);
  assign ais      = (state == ST_AIS);

  // Pointer byte for the current slot
  always_comb begin
    byte_c = 8'h00;
    if (state == ST_AIS) begin
      byte_c = 8'hFF;
    end else begin
      case (idx)
        4'd0:       byte_c = {fr_ndf, SSBITS, fr_ptr[9:8]};
        4'd1, 4'd2: byte_c = {4'b1001, SSBITS, 2'b11};
        4'd3:       byte_c = fr_ptr[7:0];
        4'd4, 4'd5: byte_c = 8'hFF;
        default:    byte_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      dout       <= 8'h00;
      vld        <= 1'b0;
      pjust      <= 1'b0;
      njust      <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      act_offset <= INIT_OFFSET;
      ld_pend    <= 1'b0;
      inc_pend   <= 1'b0;
      dec_pend   <= 1'b0;
      ld_val     <= 10'd0;
      holdoff    <= 2'd0;
      idx        <= IW'(NBYTES);
      fr_ndf     <= NDF_NORM;
      fr_ptr     <= 10'd0;
    end else begin
      ack <= 1'b0;
      err <= ld_bad_c;
      vld <= 1'b0;

      // A request arriving on the executing txsof stays pending for the next frame
      ld_pend <= (ld_pend && !(txsof && exec_ld_c)) || ld_ok_c;
      if (ld_ok_c) ld_val <= ld_offset;

      if (inc_req && !dec_req) begin
        inc_pend <= 1'b1;
        dec_pend <= 1'b0;
      end else if (dec_req && !inc_req) begin
        dec_pend <= 1'b1;
        inc_pend <= 1'b0;
      end else if (txsof && clr_adj_c) begin
        inc_pend <= 1'b0;
        dec_pend <= 1'b0;
      end

      if (txsof) begin
        act_offset <= act_nxt_c;
        holdoff    <= hold_nxt_c;
        ack        <= ack_c;
        pjust      <= pj_c;
        njust      <= nj_c;
        fr_ndf     <= ndf_c;
        fr_ptr     <= ptr_c;
        idx        <= IW'(0);
      end else if (en && idx < IW'(NBYTES)) begin
        vld  <= 1'b1;
        dout <= byte_c;
        idx  <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ptrgen.sv
// Directed bench for ptrgen: per-frame vector table plus hand sequences for slot, reset corners.
module tb_ptrgen;

  logic       clk19 = 1'b0;
  logic       rst;
  logic       txsof;
  logic       en;
  logic [9:0] ld_offset;
  logic       ld_req;
  logic       inc_req;
  logic       dec_req;
  logic       ais_req;
  logic [7:0] dout;
  logic       vld;
  logic       pjust;
  logic       njust;
  logic       ack;
  logic       err;
  logic [9:0] act_offset;
  logic       ais;

  int nvec = 0;
  int nmis = 0;

  always #5 clk19 = ~clk19;

  ptrgen dut (
    .clk19(clk19), .rst(rst), .txsof(txsof), .en(en),
    .ld_offset(ld_offset), .ld_req(ld_req), .inc_req(inc_req),
    .dec_req(dec_req), .ais_req(ais_req), .dout(dout), .vld(vld),
    .pjust(pjust), .njust(njust), .ack(ack), .err(err),
    .act_offset(act_offset), .ais(ais)
  );

  typedef struct {
    logic       ld;
    logic [9:0] off;
    logic       inc;
    logic       dec;
    logic       ais_r;
    logic       e_err;
    logic       e_ack;
    logic       e_pj;
    logic       e_nj;
    logic       e_ais;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [9:0] e_act;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] fb [0:9];
  int         nv;
  logic       f_ack, f_pj, f_nj, f_ais;

  task automatic chk(input string name, input logic [71:0] actv, input logic [71:0] expv);
    nvec++;
    if (actv !== expv) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, actv, expv);
    end
  endtask

  task automatic step();
    @(posedge clk19);
    #1;
  endtask

  task automatic add(input logic ld, input logic [9:0] off, input logic inc, input logic dec,
                     input logic ais_r, input logic e_err, input logic e_ack, input logic e_pj,
                     input logic e_nj, input logic e_ais, input logic [7:0] h1,
                     input logic [7:0] h2, input logic [9:0] e_act);
    vec_t v;
    v.ld = ld; v.off = off; v.inc = inc; v.dec = dec; v.ais_r = ais_r;
    v.e_err = e_err; v.e_ack = e_ack; v.e_pj = e_pj; v.e_nj = e_nj; v.e_ais = e_ais;
    v.h1 = h1; v.h2 = h2; v.e_act = e_act;
    tbl.push_back(v);
  endtask

  // One frame: txsof, then n_en slot strobes; every vld byte is collected into fb
  task automatic run_frame(input int n_en, input logic en_at_sof);
    nv = 0;
    txsof = 1'b1;
    en    = en_at_sof;
    step();
    txsof = 1'b0;
    en    = 1'b0;
    f_ack = ack; f_pj = pjust; f_nj = njust; f_ais = ais;
    if (vld) begin
      fb[0] = dout;
      nv++;
    end
    for (int i = 0; i < n_en; i++) begin
      en = 1'b1;
      step();
      if (vld) begin
        if (nv < 10) fb[nv] = dout;
        nv++;
      end
    end
    en = 1'b0;
    step();
  endtask

  function automatic logic [71:0] frame_bits();
    return {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7], fb[8]};
  endfunction

  initial begin
    vec_t t;
    logic [71:0] expf;
    int   vcnt;

    rst = 1'b0; txsof = 1'b0; en = 1'b0; ld_offset = 10'd0;
    ld_req = 1'b0; inc_req = 1'b0; dec_req = 1'b0; ais_req = 1'b0;
    for (int i = 0; i < 10; i++) fb[i] = 8'h00;

    //   ld off  inc dec ais  err ack pj nj eais  h1     h2     act
    add(1, 522, 0, 0, 0,  0, 1, 0, 0, 0, 8'h9A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   1, 0, 0,  0, 1, 1, 0, 0, 8'h68, 8'hA0, 523);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0B, 523);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0B, 523);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0B, 523);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0B, 523);
    add(0, 0,   0, 1, 0,  0, 1, 0, 1, 0, 8'h6B, 8'h5E, 522);
    add(0, 0,   0, 1, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6A, 8'h0A, 522);
    add(0, 0,   0, 0, 0,  0, 1, 0, 1, 0, 8'h6B, 8'h5F, 521);
    add(1, 782, 0, 0, 0,  0, 1, 0, 0, 0, 8'h9B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   1, 0, 0,  0, 1, 1, 0, 0, 8'h69, 8'hA4, 0);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h68, 8'h00, 0);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h68, 8'h00, 0);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h68, 8'h00, 0);
    add(0, 0,   0, 1, 0,  0, 1, 0, 1, 0, 8'h69, 8'h55, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   1, 0, 1,  0, 0, 0, 0, 1, 8'hFF, 8'hFF, 782);
    add(0, 0,   0, 0, 1,  0, 0, 0, 0, 1, 8'hFF, 8'hFF, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h9B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 8'h6B, 8'h0E, 782);
    add(0, 0,   0, 0, 0,  0, 1, 1, 0, 0, 8'h69, 8'hA4, 0);
    add(1, 800, 0, 0, 0,  1, 0, 0, 0, 0, 8'h68, 8'h00, 0);

    // Reset values while rst is held low
    repeat (3) step();
    chk("rst dout", dout, 8'h00);
    chk("rst vld", vld, 1'b0);
    chk("rst act", act_offset, 10'd0);
    chk("rst flags", {pjust, njust, ack, err, ais}, 5'b0);
    rst = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      ais_req = t.ais_r; ld_req = t.ld; ld_offset = t.off; inc_req = t.inc; dec_req = t.dec;
      step();
      ld_req = 1'b0; inc_req = 1'b0; dec_req = 1'b0;
      chk($sformatf("v%0d err", i), err, t.e_err);
      run_frame(9, 1'b0);
      expf = t.e_ais ? {9{8'hFF}} : {t.h1, 8'h9B, 8'h9B, t.h2, 16'hFFFF, 24'h000000};
      chk($sformatf("v%0d ack", i), f_ack, t.e_ack);
      chk($sformatf("v%0d pjust", i), f_pj, t.e_pj);
      chk($sformatf("v%0d njust", i), f_nj, t.e_nj);
      chk($sformatf("v%0d ais", i), f_ais, t.e_ais);
      chk($sformatf("v%0d nbytes", i), nv, 9);
      chk($sformatf("v%0d frame", i), frame_bits(), expf);
      chk($sformatf("v%0d act", i), act_offset, t.e_act);
    end
    ais_req = 1'b0;

    // A 10th strobe is ignored; dout holds the last byte while vld is low
    run_frame(10, 1'b0);
    chk("extra en nbytes", nv, 9);
    chk("hold vld", vld, 1'b0);
    chk("hold dout", dout, 8'h00);

    // Strobe coincident with txsof is not counted
    run_frame(9, 1'b1);
    chk("sof en nbytes", nv, 9);
    chk("sof en h1", fb[0], 8'h68);

    // Asynchronous reset in the middle of a load frame
    ld_req = 1'b1; ld_offset = 10'd522;
    step();
    ld_req = 1'b0;
    txsof = 1'b1;
    step();
    txsof = 1'b0;
    en = 1'b1;
    step();
    chk("pre-rst h1", dout, 8'h9A);
    step();
    en = 1'b0;
    chk("pre-rst y", dout, 8'h9B);
    chk("pre-rst act", act_offset, 10'd522);
    #2 rst = 1'b0;
    #1;
    chk("async dout", dout, 8'h00);
    chk("async vld", vld, 1'b0);
    chk("async act", act_offset, 10'd0);
    step();
    rst = 1'b1;
    step();
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      step();
      if (vld) vcnt++;
    end
    en = 1'b0;
    chk("post-rst idle vld", vcnt, 0);
    run_frame(9, 1'b0);
    chk("post-rst ack", f_ack, 1'b0);
    chk("post-rst frame", frame_bits(), {8'h68, 8'h9B, 8'h9B, 8'h00, 16'hFFFF, 24'h000000});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
